ys_poly_small_inv3: RTL

Sequential inverse of the mode-3 small-polynomial transform, where g'[i] = 3·(g[i-1] − g[i]) for i > 0 and g'[0] = −3·g[0]. The block recovers g from g' by a running prefix computation mod 2^13: g[0] = −inv3·g'[0], and g[i] = g[i-1] − inv3·g'[i], with inv3 = 2731 (3·2731 ≡ 1 mod 8192). It streams 8 coefficients per cycle from the source RAM (ram1) to the destination RAM (ram2) and sits next to the mode-3 datapath in the ys_poly_small engine.

---
 rtl/ys_poly_small_inv3.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ys_poly_small_inv3.sv
// ys_poly_small_inv3: streaming inverse of the mode-3 small-poly transform, 8 lanes per row.
// Optional build macro YS_POLY_SMALL_INV3_PADCLR_EN zeroes the padding lanes of the last row.
`ifndef NTRU_N
`define NTRU_N 509
`endif
`ifndef DW_13
`define DW_13 13
`endif
`ifndef DW_PH
`define DW_PH 52
`endif

module ys_poly_small_inv3_lane #(
  parameter int W = 13
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] p_o
);
  // 3 * 2731 == 1 mod 2^13
  localparam logic [W-1:0] INV3 = W'(2731);
  assign p_o = x_i * INV3;
endmodule

module ys_poly_small_inv3 #(
  parameter int N  = `NTRU_N,
  parameter int AW = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ram1_en,
  output logic [AW-1:0]     ram1_addr,
  input  logic [`DW_PH-1:0] ram1_douta,
  input  logic [`DW_PH-1:0] ram1_doutb,
  output logic              ram2_we,
  output logic [AW-1:0]     ram2_addr,
  output logic [`DW_PH-1:0] ram2_dina,
  output logic [`DW_PH-1:0] ram2_dinb
);
  localparam int L      = 8;
  localparam int W      = `DW_13;
  localparam int R      = (N + 7) / 8;
  localparam int STAGES = 2;
  localparam logic [AW-1:0] LAST = AW'(R - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state_q;
  logic                    busy_q, done_q, drain_q;
  logic [STAGES:0]         vld_pipe_q;
  logic [AW-1:0]           raddr_q, a1_q, a2_q;
  logic [L-1:0][W-1:0]     x, p_d, p_q, g_raw, g_out;
  logic [W-1:0]            carry_q;

  assign x = {ram1_doutb, ram1_douta};

  for (genvar k = 0; k < L; k++) begin : g_lane
    ys_poly_small_inv3_lane #(.W(W)) u_lane (.x_i(x[k]), .p_o(p_d[k]));
  end

  // Running prefix within the row, seeded by the previous row's last result.
  always_comb begin
    logic [W-1:0] acc;
    acc   = '0;
    g_raw = '0;
    g_out = '0;
    for (int k = 0; k < L; k++) begin
      acc      = acc + p_q[k];
      g_raw[k] = carry_q - acc;
      g_out[k] = g_raw[k];
`ifdef YS_POLY_SMALL_INV3_PADCLR_EN
      if (int'({a2_q, 3'(k)}) >= N) g_out[k] = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drain_q    <= 1'b0;
      vld_pipe_q <= '0;
      raddr_q    <= '0;
      a1_q       <= '0;
      a2_q       <= '0;
      p_q        <= '0;
      carry_q    <= '0;
    end else begin
      vld_pipe_q[STAGES:1] <= vld_pipe_q[STAGES-1:0];
      a1_q <= raddr_q;
      a2_q <= a1_q;
      if (vld_pipe_q[1]) p_q <= p_d;
      if (vld_pipe_q[2]) carry_q <= g_raw[L-1];
      case (state_q)
        IDLE: if (start) begin
          state_q       <= RUN;
          busy_q        <= 1'b1;
          vld_pipe_q[0] <= 1'b1;
          raddr_q       <= '0;
          carry_q       <= '0;
        end
        RUN: if (raddr_q == LAST) begin
          vld_pipe_q[0] <= 1'b0;
          drain_q       <= 1'b0;
          state_q       <= DRAIN;
        end else begin
          raddr_q <= raddr_q + AW'(1);
        end
        DRAIN: if (drain_q) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end else begin
          drain_q <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ram1_en   = vld_pipe_q[0];
  assign ram1_addr = raddr_q;
  assign ram2_we   = vld_pipe_q[STAGES];
  assign ram2_addr = a2_q;
  assign ram2_dina = ram2_we ? g_out[3:0] : '0;
  assign ram2_dinb = ram2_we ? g_out[7:4] : '0;
endmodule
